counter_ctrl: RTL and testbench
===============================

Name: counter_ctrl

Overview:
- Control-side master for the up/down loadable counter. It drives that counter's load_n, up_down, ce and data_load inputs and consumes its count_out, max_count and zero outputs.
- It accepts a one-shot command: start value, direction and repetition count. It then sequences load, run, terminal-count reload and completion.
- A shadow model of the expected count flags any counter misbehaviour.
- It sits between a CSR/test sequencer and the counter instance, and replaces hand-driven counter stimulus in system-level use.

Parameters:
- WIDTH, 4, counter data width; must match the attached counter.
- REP_W, 8, width of the repetition count and of the hit counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_start  in  1  one-cycle command strobe; accepted only in IDLE, ignored otherwise.
- cmd_up  in  1  direction: 1 = up (terminal = max_count), 0 = down (terminal = zero).
- cmd_val  in  WIDTH  start/reload value.
- cmd_reps  in  REP_W  terminal hits before done; 0 = run continuously.
- pause  in  1  level; holds the counter (ce=0) while high in RUN.
- abort  in  1  one-cycle strobe; returns to IDLE from any state.
- load_n  out  1  counter load, active low.
- up_down  out  1  counter direction.
- ce  out  1  counter enable.
- data_load  out  WIDTH  counter load value.
- count_out  in  WIDTH  counter value.
- max_count  in  1  counter at all-ones.
- zero  in  1  counter at zero.
- busy  out  1  high in LOAD/RUN.
- done  out  1  one-cycle pulse on completion.
- hit_cnt  out  REP_W  terminal hits in the current command.
- cnt_err  out  1  sticky shadow-mismatch flag.

Behaviour:
- Reset (rst high, async): state=IDLE, load_n=1, ce=0, up_down=1, data_load=0, busy=0, done=0, hit_cnt=0, cnt_err=0, shadow=0, and all latched cfg = 0.
- The attached counter gives load priority over ce: with load_n=0 it loads data_load at the next edge regardless of ce.
- Config register: cmd_up, cmd_val and cmd_reps are latched on an accepted cmd_start. up_down and data_load are driven from the latched cfg at all times.
- IDLE:
  - outputs idle (load_n=1, ce=0).
  - cmd_start -> LOAD; hit_cnt cleared; cnt_err cleared.
- LOAD (exactly 1 cycle):
  - load_n=0, ce=0.
  - At the edge: shadow<=cfg_val; -> RUN.
- RUN: term = cfg_up ? max_count : zero. Defaults are ce=~pause, load_n=1. The first match in order wins:
  - abort -> IDLE. Outputs idle in that cycle; no done.
  - pause -> stay in RUN, ce=0, no term evaluation, shadow holds.
  - term and (cfg_reps==0 or hit_cnt+1 < cfg_reps):
    - load_n=0 this same cycle (Mealy) to reload.
    - hit_cnt<=hit_cnt+1, saturating at all-ones when cfg_reps==0.
    - shadow<=cfg_val.
  - term and hit_cnt+1 == cfg_reps:
    - ce=0 this cycle (Mealy).
    - hit_cnt<=cfg_reps; -> DONE.
  - otherwise: shadow <= shadow ±1, modulo 2^WIDTH.
- DONE (1 cycle): done=1, outputs idle; -> IDLE.
- abort in LOAD -> IDLE; the counter may or may not have loaded. abort wins over cmd_start and over term.
- Start value already terminal: e.g. up with cmd_val=all-ones gives a hit on the first RUN cycle. Legal; counts as one hit.
- busy = (state==LOAD or RUN), registered from the next state so it rises the cycle after cmd_start.
- Shadow check: in every RUN cycle, count_out != shadow sets cnt_err. It stays set until the next accepted cmd_start or rst. There is no check in IDLE, LOAD or DONE.
- done and abort never coincide. After done, count_out holds at the terminal value, because ce=0 from the final term cycle onward.

Decomposition:
- Package counter_ctrl_pkg:
  - state enum ctrl_state_e {IDLE, LOAD, RUN, DONE}.
  - default WIDTH and REP_W localparams.
  - helper function term_hit(up, max_count, zero).
- One natural sub-module, counter_shadow: the shadow register plus comparator and sticky cnt_err.
- The FSM and hit counter stay in counter_ctrl.

Test Plan:
- WIDTH=4, up, cmd_val=13, cmd_reps=2 -> LOAD 1 cycle; count_out 13,14,15 with load_n=0 at 15; then 13,14,15 with ce=0 at 15; done pulses 1 cycle later; hit_cnt=2; cnt_err=0; total 8 cycles from cmd_start to done.
- Down, cmd_val=2, cmd_reps=1 -> count_out 2,1,0; ce=0 at 0; done next cycle; count_out stays 0.
- Up, cmd_val=15, cmd_reps=3 -> hit on each RUN cycle (15 reloaded each time); done after LOAD+3 RUN cycles; hit_cnt=3.
- cmd_reps=0, down from 3, with pause high 2 cycles mid-run, then abort after 12 cycles -> count holds during pause; reloads at every 0; no done; busy low the cycle after abort; hit_cnt equals the number of zero hits.
- Faulty counter model that skips from 5 to 7 during an up run from 4 -> cnt_err rises the cycle count_out=7 is seen and stays high through done; cleared by the next cmd_start.
- rst asserted mid-RUN, asynchronously between edges -> all outputs at reset values immediately; cmd_start after release runs normally.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// ============================================================================
// Module : counter_ctrl_pkg
// Brief  : Shared types, defaults and helpers for the counter control master.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package counter_ctrl_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_REP_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } ctrl_state_e;

    // Terminal condition depends on direction: top of range going up, zero going down.
    function automatic logic term_hit(input logic up, input logic at_max, input logic at_zero);
        return up ? at_max : at_zero;
    endfunction

endpackage

`default_nettype wire

// File: rtl/counter_shadow.sv
// ============================================================================
// Module : counter_shadow
// Brief  : Expected-count shadow register with comparator and sticky error.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module counter_shadow
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             up_i,
    input  logic [WIDTH-1:0] val_i,
    input  logic             check_i,
    input  logic [WIDTH-1:0] count_i,
    output logic             err_o
);

    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             err_q, err_d;
    logic             w_mismatch;

    assign w_mismatch = check_i && (count_i != shadow_q);

    always_comb begin
        shadow_d = shadow_q;
        err_d    = err_q;
        if (load_i) begin
            shadow_d = val_i;
        end else if (step_i) begin
            shadow_d = up_i ? (shadow_q + C_ONE) : (shadow_q - C_ONE);
        end
        if (clr_i) begin
            err_d = 1'b0;
        end else if (w_mismatch) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            err_q    <= err_d;
        end
    end

    // Flag is visible in the same cycle the bad count is presented.
    assign err_o = err_q | w_mismatch;

endmodule

`default_nettype wire

// File: rtl/counter_ctrl.sv
// ============================================================================
// Module : counter_ctrl
// Brief  : Command-driven sequencer for an up/down loadable counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int REP_W = DEF_REP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_start,
    input  logic             cmd_up,
    input  logic [WIDTH-1:0] cmd_val,
    input  logic [REP_W-1:0] cmd_reps,
    input  logic             pause,
    input  logic             abort,
    output logic             load_n,
    output logic             up_down,
    output logic             ce,
    output logic [WIDTH-1:0] data_load,
    input  logic [WIDTH-1:0] count_out,
    input  logic             max_count,
    input  logic             zero,
    output logic             busy,
    output logic             done,
    output logic [REP_W-1:0] hit_cnt,
    output logic             cnt_err
);

    localparam logic [REP_W-1:0] C_HIT_ONE = {{(REP_W-1){1'b0}}, 1'b1};

    ctrl_state_e      state_q, state_d;
    logic             cfg_dn_q, cfg_dn_d;
    logic [WIDTH-1:0] cfg_val_q, cfg_val_d;
    logic [REP_W-1:0] cfg_reps_q, cfg_reps_d;
    logic [REP_W-1:0] hit_q, hit_d;
    logic             busy_q;

    logic             w_term;
    logic [REP_W:0]   w_hit_inc;
    logic             w_sh_load, w_sh_step, w_sh_clr, w_sh_check;

    // Direction is held inverted so a cleared config still drives up_down high.
    assign up_down   = ~cfg_dn_q;
    assign data_load = cfg_val_q;
    assign w_term    = term_hit(~cfg_dn_q, max_count, zero);
    assign w_hit_inc = {1'b0, hit_q} + {{REP_W{1'b0}}, 1'b1};

    always_comb begin
        state_d    = state_q;
        cfg_dn_d   = cfg_dn_q;
        cfg_val_d  = cfg_val_q;
        cfg_reps_d = cfg_reps_q;
        hit_d      = hit_q;
        load_n     = 1'b1;
        ce         = 1'b0;
        w_sh_load  = 1'b0;
        w_sh_step  = 1'b0;
        w_sh_clr   = 1'b0;
        w_sh_check = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_start && !abort) begin
                    state_d    = LOAD;
                    cfg_dn_d   = ~cmd_up;
                    cfg_val_d  = cmd_val;
                    cfg_reps_d = cmd_reps;
                    hit_d      = '0;
                    w_sh_clr   = 1'b1;
                end
            end
            LOAD: begin
                load_n = 1'b0;
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    w_sh_load = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                w_sh_check = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (!pause) begin
                    ce = 1'b1;
                    if (w_term) begin
                        if ((cfg_reps_q == '0) || (w_hit_inc < {1'b0, cfg_reps_q})) begin
                            load_n    = 1'b0;
                            w_sh_load = 1'b1;
                            if (hit_q != '1) begin
                                hit_d = hit_q + C_HIT_ONE;
                            end
                        end else begin
                            // Freeze the counter on its terminal value for completion.
                            ce      = 1'b0;
                            hit_d   = cfg_reps_q;
                            state_d = DONE;
                        end
                    end else begin
                        w_sh_step = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cfg_dn_q   <= 1'b0;
            cfg_val_q  <= '0;
            cfg_reps_q <= '0;
            hit_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_dn_q   <= cfg_dn_d;
            cfg_val_q  <= cfg_val_d;
            cfg_reps_q <= cfg_reps_d;
            hit_q      <= hit_d;
            busy_q     <= (state_d == LOAD) || (state_d == RUN);
        end
    end

    assign busy    = busy_q;
    assign done    = (state_q == DONE);
    assign hit_cnt = hit_q;

    counter_shadow #(
        .WIDTH (WIDTH)
    ) u_shadow (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (w_sh_clr),
        .load_i  (w_sh_load),
        .step_i  (w_sh_step),
        .up_i    (~cfg_dn_q),
        .val_i   (cfg_val_q),
        .check_i (w_sh_check),
        .count_i (count_out),
        .err_o   (cnt_err)
    );

endmodule

`default_nettype wire

// File: tb/tb_counter_ctrl.sv
// ============================================================================
// Module : tb_counter_ctrl
// Brief  : Directed bench for counter_ctrl driving a behavioural counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_counter_ctrl;

    localparam int W = 4;
    localparam int R = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_start, cmd_up, pause, abort;
    logic [W-1:0] cmd_val;
    logic [R-1:0] cmd_reps;
    logic         load_n, up_down, ce, busy, done, cnt_err;
    logic [W-1:0] data_load, count_out;
    logic         max_count, zero;
    logic [R-1:0] hit_cnt;

    logic [W-1:0] cnt;
    logic         fault;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Attached counter: load has priority over enable; optional 5->7 skip fault.
    always @(posedge clk or posedge rst) begin
        if (rst)          cnt <= '0;
        else if (!load_n) cnt <= data_load;
        else if (ce) begin
            if (up_down) cnt <= (fault && cnt == W'(5)) ? W'(7) : cnt + W'(1);
            else         cnt <= cnt - W'(1);
        end
    end

    assign count_out = cnt;
    assign max_count = &cnt;
    assign zero      = (cnt == '0);

    counter_ctrl #(.WIDTH(W), .REP_W(R)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_start (cmd_start),
        .cmd_up    (cmd_up),
        .cmd_val   (cmd_val),
        .cmd_reps  (cmd_reps),
        .pause     (pause),
        .abort     (abort),
        .load_n    (load_n),
        .up_down   (up_down),
        .ce        (ce),
        .data_load (data_load),
        .count_out (count_out),
        .max_count (max_count),
        .zero      (zero),
        .busy      (busy),
        .done      (done),
        .hit_cnt   (hit_cnt),
        .cnt_err   (cnt_err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One clock: apply pause/abort for the new cycle, then check outputs (negative = skip).
    task automatic step(input string tag, input logic p, input logic a,
                        input int c, input logic ln, input logic e, input logic d, input int h);
        cyc();
        pause = p;
        abort = a;
        #2;
        if (c >= 0) chk({tag, ".cnt"}, count_out, c);
        chk({tag, ".load_n"}, load_n, ln);
        chk({tag, ".ce"}, ce, e);
        chk({tag, ".done"}, done, d);
        if (h >= 0) chk({tag, ".hit"}, hit_cnt, h);
    endtask

    // Strobe a command and check the single LOAD cycle; returns inside LOAD.
    task automatic start(input string tag, input logic up, input int val, input int reps);
        cyc();
        cmd_start = 1'b1;
        cmd_up    = up;
        cmd_val   = W'(val);
        cmd_reps  = R'(reps);
        #2;
        chk({tag, ".busy_idle"}, busy, 0);
        cyc();
        cmd_start = 1'b0;
        #2;
        chk({tag, ".ld_load_n"}, load_n, 0);
        chk({tag, ".ld_ce"}, ce, 0);
        chk({tag, ".ld_busy"}, busy, 1);
        chk({tag, ".ld_dir"}, up_down, up);
        chk({tag, ".ld_val"}, data_load, val);
        chk({tag, ".ld_err"}, cnt_err, 0);
    endtask

    initial begin
        rst = 1'b1; cmd_start = 1'b0; cmd_up = 1'b0; cmd_val = '0; cmd_reps = '0;
        pause = 1'b0; abort = 1'b0; fault = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.load_n", load_n, 1);
        chk("rst.ce", ce, 0);
        chk("rst.up_down", up_down, 1);
        chk("rst.data_load", data_load, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.hit", hit_cnt, 0);
        chk("rst.err", cnt_err, 0);
        rst = 1'b0;

        // Up from 13, two hits: reload at first 15, stop on second.
        start("t1", 1'b1, 13, 2);
        step("t1r1", 0, 0, 13, 1, 1, 0, 0);
        step("t1r2", 0, 0, 14, 1, 1, 0, 0);
        step("t1r3", 0, 0, 15, 0, 1, 0, 0);
        step("t1r4", 0, 0, 13, 1, 1, 0, 1);
        step("t1r5", 0, 0, 14, 1, 1, 0, 1);
        step("t1r6", 0, 0, 15, 1, 0, 0, 1);
        step("t1dn", 0, 0, 15, 1, 0, 1, 2);
        chk("t1dn.busy", busy, 0);
        chk("t1dn.err", cnt_err, 0);
        step("t1id", 0, 0, 15, 1, 0, 0, 2);

        // Down from 2, single hit at zero.
        start("t2", 1'b0, 2, 1);
        step("t2r1", 0, 0, 2, 1, 1, 0, 0);
        step("t2r2", 0, 0, 1, 1, 1, 0, 0);
        step("t2r3", 0, 0, 0, 1, 0, 0, 0);
        step("t2dn", 0, 0, 0, 1, 0, 1, 1);
        step("t2id", 0, 0, 0, 1, 0, 0, 1);

        // Start value already terminal: every RUN cycle is a hit.
        start("t3", 1'b1, 15, 3);
        step("t3r1", 0, 0, 15, 0, 1, 0, 0);
        step("t3r2", 0, 0, 15, 0, 1, 0, 1);
        step("t3r3", 0, 0, 15, 1, 0, 0, 2);
        step("t3dn", 0, 0, 15, 1, 0, 1, 3);

        // Continuous down from 3 with a two-cycle pause, aborted on RUN cycle 12.
        start("t4", 1'b0, 3, 0);
        step("t4r1", 0, 0, 3, 1, 1, 0, 0);
        step("t4r2", 0, 0, 2, 1, 1, 0, 0);
        step("t4p1", 1, 0, 1, 1, 0, 0, 0);
        step("t4p2", 1, 0, 1, 1, 0, 0, 0);
        step("t4r5", 0, 0, 1, 1, 1, 0, 0);
        step("t4r6", 0, 0, 0, 0, 1, 0, 0);
        step("t4r7", 0, 0, 3, 1, 1, 0, 1);
        step("t4r8", 0, 0, 2, 1, 1, 0, 1);
        step("t4r9", 0, 0, 1, 1, 1, 0, 1);
        step("t4r10", 0, 0, 0, 0, 1, 0, 1);
        step("t4r11", 0, 0, 3, 1, 1, 0, 2);
        step("t4ab", 0, 1, 2, 1, 0, 0, 2);
        step("t4id", 0, 0, 2, 1, 0, 0, 2);
        chk("t4id.busy", busy, 0);
        chk("t4id.err", cnt_err, 0);

        // Abort during LOAD returns to idle without running.
        cyc();
        cmd_start = 1'b1; cmd_up = 1'b1; cmd_val = W'(9); cmd_reps = R'(1);
        step("t5ld", 0, 1, -1, 0, 0, 0, 0);
        cmd_start = 1'b0;
        step("t5id", 0, 0, -1, 1, 0, 0, 0);
        chk("t5id.busy", busy, 0);

        // Faulty counter skips 5->7; error sticks through done.
        fault = 1'b1;
        start("t6", 1'b1, 4, 1);
        step("t6r1", 0, 0, 4, 1, 1, 0, 0);
        chk("t6r1.err", cnt_err, 0);
        step("t6r2", 0, 0, 5, 1, 1, 0, 0);
        chk("t6r2.err", cnt_err, 0);
        step("t6r3", 0, 0, 7, 1, 1, 0, 0);
        chk("t6r3.err", cnt_err, 1);
        for (int i = 8; i < 15; i++) step("t6run", 0, 0, i, 1, 1, 0, 0);
        step("t6last", 0, 0, 15, 1, 0, 0, 0);
        step("t6dn", 0, 0, 15, 1, 0, 1, 1);
        chk("t6dn.err", cnt_err, 1);
        fault = 1'b0;
        start("t6clr", 1'b1, 14, 1);
        step("t6c1", 0, 0, 14, 1, 1, 0, 0);
        step("t6c2", 0, 0, 15, 1, 0, 0, 0);
        step("t6cdn", 0, 0, 15, 1, 0, 1, 1);
        chk("t6cdn.err", cnt_err, 0);

        // Asynchronous reset between edges in the middle of a run.
        start("t7", 1'b1, 14, 0);
        step("t7r1", 0, 0, 14, 1, 1, 0, 0);
        step("t7r2", 0, 0, 15, 0, 1, 0, 0);
        step("t7r3", 0, 0, 14, 1, 1, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t7rst.load_n", load_n, 1);
        chk("t7rst.ce", ce, 0);
        chk("t7rst.up_down", up_down, 1);
        chk("t7rst.data_load", data_load, 0);
        chk("t7rst.busy", busy, 0);
        chk("t7rst.hit", hit_cnt, 0);
        chk("t7rst.done", done, 0);
        chk("t7rst.err", cnt_err, 0);
        cyc();
        rst = 1'b0;
        start("t8", 1'b0, 1, 1);
        step("t8r1", 0, 0, 1, 1, 1, 0, 0);
        step("t8r2", 0, 0, 0, 1, 0, 0, 0);
        step("t8dn", 0, 0, 0, 1, 0, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
